keygen_sched: RTL

- Round-robin scheduler that shares one KeyGen core (8-bit p/q in; e, d, n out; single-cycle start/finish) among NREQ requesters.
- Accepts a (p, q) job from one requester at a time and launches the core with a 1-cycle start pulse.
- Waits for finish or timeout, then returns e/d/n tagged with the requester ID over a valid/ready response channel.
- Sits between the RSA host-side request ports and the key generation datapath.

---
 rtl/keygen_sched.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/keygen_sched.sv
// Round-robin scheduler that shares one KeyGen core between NREQ requesters,
// keeping a single job in flight and returning tagged results over valid/ready.
module keygen_sched #(
    parameter int NREQ    = 2,
    parameter int IDW     = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_p,
    input  logic [8*NREQ-1:0]   req_q,
    output logic [NREQ-1:0]     req_ready,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [IDW-1:0]      resp_id,
    output logic [7:0]          resp_e,
    output logic [15:0]         resp_d,
    output logic [15:0]         resp_n,
    output logic [1:0]          resp_err,
    output logic                kg_start,
    output logic [7:0]          kg_p,
    output logic [7:0]          kg_q,
    input  logic [7:0]          kg_e,
    input  logic [15:0]         kg_d,
    input  logic [15:0]         kg_n,
    input  logic                kg_finish,
    output logic                kg_clr,
    output logic                busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARB    = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    localparam int NSLOT = 2**IDW;
    localparam int CW    = $clog2(TIMEOUT) + 1;

    logic [2:0]     state_reg, state_next;
    logic [IDW-1:0] rr_ptr_reg;
    logic [IDW-1:0] id_reg;
    logic [7:0]     p_reg, q_reg;
    logic [CW-1:0]  cnt_reg;
    logic [7:0]     e_reg;
    logic [15:0]    d_reg, n_reg;
    logic [1:0]     err_reg;

    // Requester inputs padded out to a power-of-two table so an IDW-bit index
    // always lands on a defined entry.
    logic [NSLOT-1:0] valid_ext;
    logic [7:0]       p_arr [NSLOT];
    logic [7:0]       q_arr [NSLOT];

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_unpack
            if (gi < NREQ) begin : g_real
                assign valid_ext[gi] = req_valid[gi];
                assign p_arr[gi]     = req_p[8*gi +: 8];
                assign q_arr[gi]     = req_q[8*gi +: 8];
            end else begin : g_pad
                assign valid_ext[gi] = 1'b0;
                assign p_arr[gi]     = 8'd0;
                assign q_arr[gi]     = 8'd0;
            end
        end
    endgenerate

    logic           grant_found;
    logic [IDW-1:0] grant_idx;

    always_comb begin
        logic [IDW:0] scan;
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, rr_ptr_reg} + (IDW+1)'(k);
            if (scan >= (IDW+1)'(NREQ)) begin
                scan = scan - (IDW+1)'(NREQ);
            end
            if (!grant_found && valid_ext[scan[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan[IDW-1:0];
            end
        end
    end

    logic arb_fire;
    assign arb_fire = (state_reg == S_ARB) && grant_found;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = arb_fire && (grant_idx == IDW'(gi));
        end
    endgenerate

    // x mod 3 via base-4 digit sums (4 == 1 mod 3); true when x is a multiple of 3.
    function automatic logic div3(input logic [7:0] x);
        logic [3:0] s;
        logic [2:0] s2;
        logic [1:0] t;
        s  = {2'b00, x[1:0]} + {2'b00, x[3:2]} + {2'b00, x[5:4]} + {2'b00, x[7:6]};
        s2 = {1'b0, s[1:0]} + {1'b0, s[3:2]};
        t  = s2[1:0] + {1'b0, s2[2]};
        return (t == 2'd0) || (t == 2'd3);
    endfunction

    logic bad_op;
    always_comb begin
        bad_op = (p_reg < 8'd2) || (q_reg < 8'd2) || (p_reg == q_reg);
        if (!bad_op) begin
            bad_op = div3(p_reg - 8'd1) || div3(q_reg - 8'd1);
        end
    end

    logic timeout_hit;
    assign timeout_hit = (state_reg == S_WAIT) && (cnt_reg == CW'(TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (|req_valid) state_next = S_ARB;
            S_ARB:    state_next = grant_found ? S_LAUNCH : S_IDLE;
            S_LAUNCH: state_next = bad_op ? S_RESP : S_WAIT;
            S_WAIT:   if (kg_finish || timeout_hit) state_next = S_RESP;
            S_RESP:   if (resp_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            rr_ptr_reg <= '0;
            id_reg     <= '0;
            p_reg      <= '0;
            q_reg      <= '0;
            cnt_reg    <= '0;
            e_reg      <= '0;
            d_reg      <= '0;
            n_reg      <= '0;
            err_reg    <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_ARB: begin
                    if (grant_found) begin
                        p_reg      <= p_arr[grant_idx];
                        q_reg      <= q_arr[grant_idx];
                        id_reg     <= grant_idx;
                        rr_ptr_reg <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    end
                end
                S_LAUNCH: begin
                    cnt_reg <= '0;
                    if (bad_op) begin
                        err_reg <= 2'd1;
                        e_reg   <= '0;
                        d_reg   <= '0;
                        n_reg   <= '0;
                    end
                end
                S_WAIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    // finish has priority over a coincident timeout
                    if (kg_finish) begin
                        err_reg <= 2'd0;
                        e_reg   <= kg_e;
                        d_reg   <= kg_d;
                        n_reg   <= kg_n;
                    end else if (timeout_hit) begin
                        err_reg <= 2'd2;
                        e_reg   <= '0;
                        d_reg   <= '0;
                        n_reg   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign kg_start   = (state_reg == S_LAUNCH) && !bad_op;
    assign kg_p       = kg_start ? p_reg : 8'd0;
    assign kg_q       = kg_start ? q_reg : 8'd0;
    assign kg_clr     = timeout_hit && !kg_finish;
    assign resp_valid = (state_reg == S_RESP);
    assign busy       = (state_reg != S_IDLE);
    assign resp_id    = id_reg;
    assign resp_e     = e_reg;
    assign resp_d     = d_reg;
    assign resp_n     = n_reg;
    assign resp_err   = err_reg;

endmodule
